mp_addsub_seq: RTL

Multi-precision add/subtract sequencer. It streams operand pairs one byte at a time, least-significant byte first, into the 8-bit carry-lookahead adder and chains the carry across bytes to form an NBYTES-wide sum or difference. It sits directly upstream of the adder datapath and owns everything the adder lacks: operand inversion for subtract, carry-in selection, byte sequencing, the registered output stage and the final-word flags.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/cla8.sv | 41 ++++
 rtl/mp_addsub_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-precision add/subtract datapath.
package alu_pkg;

  localparam int unsigned NBYTES_DEF = 4;
  localparam int unsigned BYTE_W     = 8;

  // Sequencer FSM encoding
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Flag bit positions for downstream status packing
  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_V = 3;
  localparam int unsigned FLG_W = 4;

  typedef logic [FLG_W-1:0] flags_t;

endpackage

// File: rtl/cla8.sv
// 8-bit carry-lookahead adder: every carry is a flat sum of generate/propagate terms.
module cla8
  import alu_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              cout
);

  logic [BYTE_W-1:0] g;
  logic [BYTE_W-1:0] p;
  logic [BYTE_W:0]   c;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  always_comb begin
    logic acc;
    logic pp;
    g   = a & b;
    p   = a ^ b;
    c   = '0;
    acc = 1'b0;
    pp  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      acc    = acc | (pp & cin);
      c[i+1] = acc;
    end
  end

  assign s    = p ^ c[BYTE_W-1:0];
  assign cout = c[BYTE_W];

endmodule

// File: rtl/mp_addsub_seq.sv
// Byte-serial multi-precision add/subtract sequencer around cla8.
module mp_addsub_seq
  import alu_pkg::*;
#(
  parameter int unsigned NBYTES = NBYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_a,
  input  logic [BYTE_W-1:0] in_b,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_s,
  output logic              out_last,
  output logic              out_c,
  output logic              out_z,
  output logic              out_n,
  output logic              out_v
);

  localparam int unsigned        IDXW     = $clog2(NBYTES);
  localparam logic [IDXW-1:0]    IDX_LAST = IDXW'(NBYTES - 1);

  state_t            state;
  state_t            state_nx;
  logic [IDXW-1:0]   idx;
  logic              carry;
  logic              z_acc;
  logic              op_sub;

  logic              accept;
  logic              first;
  logic              last;
  logic              op_eff;
  logic              cin;
  logic [BYTE_W-1:0] b_eff;
  logic [BYTE_W-1:0] sum;
  logic              cout;
  logic              z_nx;
  flags_t            flags_nx;
  flags_t            flags_q;

  // Accept whenever the output stage is free or being drained; flush blocks intake
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ST_IDLE;
    end else if (accept) begin
      case (state)
        ST_IDLE: state_nx = ST_RUN;
        ST_RUN:  if (last) state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // FSM decode: in IDLE the presented byte is byte 0 of a new word
  always_comb begin
    first = 1'b0;
    if (state == ST_IDLE) first = 1'b1;
  end

  // Operand conditioning and carry-in select for the adder
  always_comb begin
    op_eff = first ? in_sub : op_sub;
    cin    = first ? in_sub : carry;
    b_eff  = in_b ^ {BYTE_W{op_eff}};
    last   = (idx == IDX_LAST);
  end

  cla8 u_cla8 (
    .a    (in_a),
    .b    (b_eff),
    .cin  (cin),
    .s    (sum),
    .cout (cout)
  );

  // Word flags, only populated for the final byte
  always_comb begin
    z_nx     = (sum == '0) && (first || z_acc);
    flags_nx = '0;
    if (last) begin
      flags_nx[FLG_C] = cout;
      flags_nx[FLG_Z] = z_nx;
      flags_nx[FLG_N] = sum[BYTE_W-1];
      flags_nx[FLG_V] = (in_a[BYTE_W-1] == b_eff[BYTE_W-1]) &&
                        (sum[BYTE_W-1] != in_a[BYTE_W-1]);
    end
  end

  // Per-word sequencing state: byte index, chained carry, zero accumulator, op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      z_acc  <= 1'b0;
      op_sub <= 1'b0;
    end else if (flush) begin
      idx    <= '0;
      carry  <= 1'b0;
      z_acc  <= 1'b0;
      op_sub <= 1'b0;
    end else if (accept) begin
      idx   <= last ? '0 : idx + IDXW'(1);
      carry <= cout;
      z_acc <= z_nx;
      if (first) op_sub <= in_sub;
    end
  end

  // Registered output stage; holds under backpressure, untouched by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_s     <= '0;
      out_last  <= 1'b0;
      flags_q   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_s     <= sum;
      out_last  <= last;
      flags_q   <= flags_nx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_c = flags_q[FLG_C];
  assign out_z = flags_q[FLG_Z];
  assign out_n = flags_q[FLG_N];
  assign out_v = flags_q[FLG_V];

endmodule
